weight_buf: RTL and testbench
=============================

Name: weight_buf

Overview:
Ping-pong weight storage between the weight bus interface unit and the MAC array. It captures the 160-word kernel stream for one output channel: 144 words of 3x3 weights and 16 words of 1x1 weights. It presents a complete bank to the MAC array while the next output channel's weights load into the other bank. Release by the MAC array frees a bank for reload.

Parameters:
DATA_W, 32, weight word width (4 x int8)
CH_WORDS, 16, words per kernel position (input-channel groups)
POS_NUM, 9, 3x3 kernel positions
BANK_WORDS, 160, POS_NUM*CH_WORDS + CH_WORDS

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
weight_wen  in  1  write strobe from weight BIU
weight_waddr  in  32  [31]=1x1 flag, [30:23]=out_ch, [11:6]=kernel pos, [5:0]=ch word
weight_wdata  in  32  weight word
weight_done  in  1  pulse: current load complete
buf_free  out  1  write bank empty; controller may issue weight_start
buf_ready  out  1  read bank holds valid weights
mac_rd_en  in  1  read request
mac_rd_pos  in  4  kernel position 0..8
mac_rd_ch  in  4  ch word 0..15
mac_rd_vld  out  1  read data valid
mac_rd_w3  out  32  3x3 word at (pos,ch)
mac_rd_w1  out  32  1x1 word at ch
mac_rd_och  out  8  out_ch tag of read bank
mac_release  in  1  pulse: read bank consumed
err_clr  in  1  clears wr_err
wr_err  out  1  sticky error flag

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n.
- Reset values: bank_vld=2'b00, wr_sel=0, rd_sel=0, wr_cnt=0, tags=0, and all outputs 0 except buf_free=1. Array contents are not reset.
- Index mapping:
  - 3x3 words (waddr[31]=0): idx = pos*16 + ch[3:0].
  - 1x1 words (waddr[31]=1): idx = 144 + ch[3:0]; pos is ignored.
- Write path:
  - When weight_wen=1 and bank_vld[wr_sel]=0: write bank[wr_sel][idx] and increment wr_cnt (8-bit).
  - Load the out_ch tag from waddr[30:23] on the first write of a load (wr_cnt==0).
  - When weight_wen=1 and bank_vld[wr_sel]=1: drop the write and set wr_err.
- Load completion, weight_done=1:
  - If bank_vld[wr_sel]=0: set bank_vld[wr_sel], toggle wr_sel, clear wr_cnt.
  - If bank_vld[wr_sel]=1: ignore it and set wr_err.
  - A wen in the same cycle as weight_done writes to the old bank first.
- buf_free = !bank_vld[wr_sel]; buf_ready = bank_vld[rd_sel]. Both are combinational from registers.
- Read path, latency 1:
  - When mac_rd_en=1 and buf_ready=1: on the next cycle drive mac_rd_vld=1, mac_rd_w3 = bank[rd_sel][pos*16+ch], mac_rd_w1 = bank[rd_sel][144+ch].
  - If pos>8: mac_rd_w3=0.
  - When mac_rd_en=1 and buf_ready=0: mac_rd_vld=0 and data holds its previous value.
  - Back-to-back reads are supported at one per cycle.
- Release:
  - mac_release=1 with buf_ready=1: clear bank_vld[rd_sel] and toggle rd_sel.
  - mac_release=1 with buf_ready=0: ignored.
  - A read issued in the same cycle as release uses the pre-release bank.
- Simultaneous done and release:
  - Different banks: both take effect.
  - Same bank (both banks full, wr_sel==rd_sel): release frees the bank; the done is evaluated on the pre-cycle bank_vld, so it is ignored and sets wr_err.
- mac_rd_och = tag[rd_sel].
- wr_err is sticky until err_clr=1. If an error event and err_clr coincide, err_clr wins.

Optional Feature:
WEIGHT_BUF_CHK_EN
- Defined: wr_err is additionally set when:
  - weight_done arrives with wr_cnt != 160;
  - a 3x3 write has pos>8;
  - any write has waddr[5:4] != 0.
  Out-of-range writes are dropped.
- Undefined: only the overflow and done-on-full cases set wr_err. Out-of-range indices are masked and written unchecked.

Decomposition:
- Shared package holds:
  - constants CH_WORDS, POS_NUM, BANK_WORDS, K1_BASE=144;
  - waddr field positions (FLAG_BIT=31, OCH_MSB=30, OCH_LSB=23, POS_MSB=11, POS_LSB=6, CH_MSB=5, CH_LSB=0);
  - typedef weight_word_t [31:0].
- Sub-module weight_bank: 160x32 flop array with one write port and two synchronous read ports. It is instantiated twice.
- Bank select, control and error logic live in weight_buf.

Test Plan:
- Load 160 words (3x3 data = idx, 1x1 data = 0xA000+ch, out_ch=5), then done → buf_ready=1, buf_free=1, och=5; read pos=2, ch=3 → next cycle vld=1, w3=35, w1=0xA003.
- Load bank0, load bank1 without release → buf_free=0; a third write → dropped, wr_err=1; err_clr → wr_err=0.
- mac_release while loading bank1 → rd_sel=1 after bank1 done; och switches to bank1 tag.
- Both banks full: same-cycle done + release → bank freed, done ignored, wr_err=1.
- Read with buf_ready=0 → vld stays 0; pos=9 → w3=0.
- Assert rst_n low mid-load (at wr_cnt=70) → asynchronous clear, buf_free=1, buf_ready=0. With WEIGHT_BUF_CHK_EN: done after 159 words → wr_err=1.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// rtl/weight_buf_pkg.sv - shared constants, address fields and index helpers for weight_buf
package weight_buf_pkg;

    localparam int DATA_W     = 32;
    localparam int CH_WORDS   = 16;
    localparam int POS_NUM    = 9;
    localparam int BANK_WORDS = POS_NUM * CH_WORDS + CH_WORDS;
    localparam int K1_BASE    = POS_NUM * CH_WORDS;

    localparam int FLAG_BIT = 31;
    localparam int OCH_MSB  = 30;
    localparam int OCH_LSB  = 23;
    localparam int POS_MSB  = 11;
    localparam int POS_LSB  = 6;
    localparam int CH_MSB   = 5;
    localparam int CH_LSB   = 0;

    localparam int IDX_W = 8;

    typedef logic [DATA_W-1:0] weight_word_t;
    typedef logic [IDX_W-1:0]  bank_idx_t;

    // 3x3 word location: pos*16 + ch, which is just the two nibbles side by side
    function automatic bank_idx_t k3_idx(input logic [3:0] pos, input logic [3:0] ch);
        return {pos, ch};
    endfunction

    // 1x1 words sit after the nine 3x3 positions
    function automatic bank_idx_t k1_idx(input logic [3:0] ch);
        return bank_idx_t'(K1_BASE) + bank_idx_t'(ch);
    endfunction

endpackage

// File: rtl/weight_buf_if.sv
// rtl/weight_buf_if.sv - weight load bus and MAC read bus of weight_buf
interface weight_buf_if;
    import weight_buf_pkg::*;

    logic         weight_wen;
    logic [31:0]  weight_waddr;
    weight_word_t weight_wdata;
    logic         weight_done;
    logic         buf_free;
    logic         buf_ready;
    logic         mac_rd_en;
    logic [3:0]   mac_rd_pos;
    logic [3:0]   mac_rd_ch;
    logic         mac_rd_vld;
    weight_word_t mac_rd_w3;
    weight_word_t mac_rd_w1;
    logic [7:0]   mac_rd_och;
    logic         mac_release;
    logic         err_clr;
    logic         wr_err;

    modport master (
        output weight_wen, weight_waddr, weight_wdata, weight_done,
        output mac_rd_en, mac_rd_pos, mac_rd_ch, mac_release, err_clr,
        input  buf_free, buf_ready, mac_rd_vld, mac_rd_w3, mac_rd_w1, mac_rd_och, wr_err
    );

    modport slave (
        input  weight_wen, weight_waddr, weight_wdata, weight_done,
        input  mac_rd_en, mac_rd_pos, mac_rd_ch, mac_release, err_clr,
        output buf_free, buf_ready, mac_rd_vld, mac_rd_w3, mac_rd_w1, mac_rd_och, wr_err
    );

endinterface

// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - 160x32 flop array, one write port, two registered read ports
module weight_bank
    import weight_buf_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  bank_idx_t    wr_idx,
    input  weight_word_t wr_data,
    input  logic         rd_en,
    input  bank_idx_t    rd_idx_a,
    input  bank_idx_t    rd_idx_b,
    output weight_word_t rd_data_a,
    output weight_word_t rd_data_b
);

    weight_word_t mem [BANK_WORDS];

    logic wr_in_range;
    logic rd_a_in_range;
    logic rd_b_in_range;

    assign wr_in_range   = wr_idx   < bank_idx_t'(BANK_WORDS);
    assign rd_a_in_range = rd_idx_a < bank_idx_t'(BANK_WORDS);
    assign rd_b_in_range = rd_idx_b < bank_idx_t'(BANK_WORDS);

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read registers only move on a read so the last data stays visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= rd_a_in_range ? mem[rd_idx_a] : '0;
            rd_data_b <= rd_b_in_range ? mem[rd_idx_b] : '0;
        end
    end

endmodule

// File: rtl/weight_buf.sv
// rtl/weight_buf.sv - ping-pong kernel weight buffer; optional checks under WEIGHT_BUF_CHK_EN
module weight_buf
    import weight_buf_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    weight_buf_if.slave  bus
);

    logic [1:0] bank_vld;
    logic [1:0] bank_vld_nxt;
    logic       wr_sel;
    logic       rd_sel;
    logic [7:0] wr_cnt;
    logic [7:0] tag0;
    logic [7:0] tag1;
    logic       wr_err_q;

    logic       rd_vld_q;
    logic       rd_bank_q;
    logic       w3_zero_q;

    // Write address decode
    logic       wr_flag;
    logic [7:0] wr_och;
    logic [5:0] wr_pos;
    logic [5:0] wr_ch;
    bank_idx_t  wr_idx;
    logic       unused_addr_bits;

    assign wr_flag = bus.weight_waddr[FLAG_BIT];
    assign wr_och  = bus.weight_waddr[OCH_MSB:OCH_LSB];
    assign wr_pos  = bus.weight_waddr[POS_MSB:POS_LSB];
    assign wr_ch   = bus.weight_waddr[CH_MSB:CH_LSB];
    assign wr_idx  = wr_flag ? k1_idx(wr_ch[3:0]) : k3_idx(wr_pos[3:0], wr_ch[3:0]);
    assign unused_addr_bits = ^{bus.weight_waddr[22:12], wr_pos[5:4], wr_ch[5:4]};

    logic       wr_full;
    logic       wr_range_err;
    logic       wr_accept;
    logic [7:0] wr_cnt_after;
    logic       done_ok;
    logic       done_cnt_err;
    logic       rel_ok;
    logic       err_set;

    assign wr_full = bank_vld[wr_sel];

`ifdef WEIGHT_BUF_CHK_EN
    assign wr_range_err = (!wr_flag && (wr_pos > 6'd8)) || (wr_ch[5:4] != 2'b00);
`else
    assign wr_range_err = 1'b0;
`endif

    assign wr_accept    = bus.weight_wen && !wr_full && !wr_range_err;
    assign wr_cnt_after = wr_cnt + (wr_accept ? 8'd1 : 8'd0);
    assign done_ok      = bus.weight_done && !wr_full;
    assign rel_ok       = bus.mac_release && bank_vld[rd_sel];

`ifdef WEIGHT_BUF_CHK_EN
    assign done_cnt_err = bus.weight_done && (wr_cnt_after != 8'(BANK_WORDS));
`else
    assign done_cnt_err = 1'b0;
`endif

    assign err_set = (bus.weight_wen && wr_full)
                   | (bus.weight_wen && wr_range_err)
                   | (bus.weight_done && wr_full)
                   | done_cnt_err;

    // Bank valid update; done and release can only both act on different banks
    always_comb begin
        bank_vld_nxt = bank_vld;
        if (rel_ok) begin
            bank_vld_nxt[rd_sel] = 1'b0;
        end
        if (done_ok) begin
            bank_vld_nxt[wr_sel] = 1'b1;
        end
    end

    // Bank select, load count and out_ch tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_vld <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_cnt   <= 8'd0;
            tag0     <= 8'd0;
            tag1     <= 8'd0;
        end else begin
            bank_vld <= bank_vld_nxt;
            if (done_ok) begin
                wr_sel <= ~wr_sel;
            end
            if (rel_ok) begin
                rd_sel <= ~rd_sel;
            end
            if (done_ok) begin
                wr_cnt <= 8'd0;
            end else if (wr_accept) begin
                wr_cnt <= wr_cnt_after;
            end
            if (wr_accept && (wr_cnt == 8'd0)) begin
                if (wr_sel) begin
                    tag1 <= wr_och;
                end else begin
                    tag0 <= wr_och;
                end
            end
        end
    end

    // Sticky error flag; a clear in the same cycle as a new error wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else if (bus.err_clr) begin
            wr_err_q <= 1'b0;
        end else if (err_set) begin
            wr_err_q <= 1'b1;
        end
    end

    // Read side
    logic         rd_fire;
    bank_idx_t    rd_idx3;
    bank_idx_t    rd_idx1;
    weight_word_t b0_w3;
    weight_word_t b0_w1;
    weight_word_t b1_w3;
    weight_word_t b1_w1;

    assign rd_fire = bus.mac_rd_en && bank_vld[rd_sel];
    assign rd_idx3 = k3_idx(bus.mac_rd_pos, bus.mac_rd_ch);
    assign rd_idx1 = k1_idx(bus.mac_rd_ch);

    weight_bank u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_accept && !wr_sel),
        .wr_idx    (wr_idx),
        .wr_data   (bus.weight_wdata),
        .rd_en     (rd_fire && !rd_sel),
        .rd_idx_a  (rd_idx3),
        .rd_idx_b  (rd_idx1),
        .rd_data_a (b0_w3),
        .rd_data_b (b0_w1)
    );

    weight_bank u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_accept && wr_sel),
        .wr_idx    (wr_idx),
        .wr_data   (bus.weight_wdata),
        .rd_en     (rd_fire && rd_sel),
        .rd_idx_a  (rd_idx3),
        .rd_idx_b  (rd_idx1),
        .rd_data_a (b1_w3),
        .rd_data_b (b1_w1)
    );

    // Remember which bank answered and whether the position was out of range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_bank_q <= 1'b0;
            w3_zero_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_fire;
            if (rd_fire) begin
                rd_bank_q <= rd_sel;
                w3_zero_q <= bus.mac_rd_pos > 4'd8;
            end
        end
    end

    assign bus.buf_free   = !bank_vld[wr_sel];
    assign bus.buf_ready  = bank_vld[rd_sel];
    assign bus.mac_rd_vld = rd_vld_q;
    assign bus.mac_rd_w3  = w3_zero_q ? '0 : (rd_bank_q ? b1_w3 : b0_w3);
    assign bus.mac_rd_w1  = rd_bank_q ? b1_w1 : b0_w1;
    assign bus.mac_rd_och = rd_sel ? tag1 : tag0;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_weight_buf.sv
// tb/tb_weight_buf.sv - directed self-checking bench for weight_buf
module tb_weight_buf;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    weight_buf_if bus();

    weight_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_range(input logic [7:0] och, input int lo, input int hi,
                              input logic [31:0] b3, input logic [31:0] b1);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            bus.weight_wen = 1'b1;
            if (i < 144) begin
                bus.weight_waddr = {1'b0, och, 11'd0, 6'(i / 16), 6'(i % 16)};
                bus.weight_wdata = b3 + 32'(i);
            end else begin
                bus.weight_waddr = {1'b1, och, 11'd0, 6'd0, 6'(i - 144)};
                bus.weight_wdata = b1 + 32'(i - 144);
            end
        end
        @(negedge clk);
        bus.weight_wen = 1'b0;
    endtask

    task automatic pulse_done();
        bus.weight_done = 1'b1;
        @(negedge clk);
        bus.weight_done = 1'b0;
    endtask

    task automatic pulse_release();
        bus.mac_release = 1'b1;
        @(negedge clk);
        bus.mac_release = 1'b0;
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] pos, input logic [3:0] ch);
        bus.mac_rd_en  = 1'b1;
        bus.mac_rd_pos = pos;
        bus.mac_rd_ch  = ch;
        @(negedge clk);
        bus.mac_rd_en  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.weight_wen   = 1'b0;
        bus.weight_waddr = '0;
        bus.weight_wdata = '0;
        bus.weight_done  = 1'b0;
        bus.mac_rd_en    = 1'b0;
        bus.mac_rd_pos   = '0;
        bus.mac_rd_ch    = '0;
        bus.mac_release  = 1'b0;
        bus.err_clr      = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("rst_free",  32'(bus.buf_free), 32'd1);
        check("rst_ready", 32'(bus.buf_ready), 32'd0);
        check("rst_vld",   32'(bus.mac_rd_vld), 32'd0);
        check("rst_err",   32'(bus.wr_err), 32'd0);
        check("rst_och",   32'(bus.mac_rd_och), 32'd0);
        check("rst_w3",    bus.mac_rd_w3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First bank: och 5, 3x3 data = idx, 1x1 data = 0xA000+ch
        load_range(8'd5, 0, 160, 32'h0, 32'hA000);
        pulse_done();
        check("l0_ready", 32'(bus.buf_ready), 32'd1);
        check("l0_free",  32'(bus.buf_free), 32'd1);
        check("l0_och",   32'(bus.mac_rd_och), 32'd5);
        rd(4'd2, 4'd3);
        check("r23_vld", 32'(bus.mac_rd_vld), 32'd1);
        check("r23_w3",  bus.mac_rd_w3, 32'd35);
        check("r23_w1",  bus.mac_rd_w1, 32'hA003);
        rd(4'd8, 4'd15);
        check("r8f_w3",  bus.mac_rd_w3, 32'd143);
        check("r8f_w1",  bus.mac_rd_w1, 32'hA00F);

        // Back-to-back reads
        bus.mac_rd_en = 1'b1; bus.mac_rd_pos = 4'd1; bus.mac_rd_ch = 4'd1;
        @(negedge clk);
        check("bb1_w3", bus.mac_rd_w3, 32'd17);
        bus.mac_rd_pos = 4'd4; bus.mac_rd_ch = 4'd5;
        @(negedge clk);
        bus.mac_rd_en = 1'b0;
        check("bb2_vld", 32'(bus.mac_rd_vld), 32'd1);
        check("bb2_w3",  bus.mac_rd_w3, 32'd69);
        check("bb2_w1",  bus.mac_rd_w1, 32'hA005);

        // Position beyond the kernel reads zero for the 3x3 word
        rd(4'd9, 4'd0);
        check("p9_vld", 32'(bus.mac_rd_vld), 32'd1);
        check("p9_w3",  bus.mac_rd_w3, 32'd0);
        check("p9_w1",  bus.mac_rd_w1, 32'hA000);

        // Second bank, no release: both full
        load_range(8'd7, 0, 160, 32'h1000, 32'hB000);
        pulse_done();
        check("l1_free",  32'(bus.buf_free), 32'd0);
        check("l1_ready", 32'(bus.buf_ready), 32'd1);
        check("l1_och",   32'(bus.mac_rd_och), 32'd5);
        check("l1_err",   32'(bus.wr_err), 32'd0);
        @(negedge clk);
        bus.weight_wen = 1'b1;
        bus.weight_waddr = {1'b0, 8'd7, 11'd0, 6'd2, 6'd3};
        bus.weight_wdata = 32'hDEAD;
        @(negedge clk);
        bus.weight_wen = 1'b0;
        check("ovf_err", 32'(bus.wr_err), 32'd1);
        rd(4'd2, 4'd3);
        check("ovf_drop", bus.mac_rd_w3, 32'd35);
        pulse_err_clr();
        check("clr_err", 32'(bus.wr_err), 32'd0);

        // Release bank0 -> bank1 presented
        pulse_release();
        check("rel_och",   32'(bus.mac_rd_och), 32'd7);
        check("rel_ready", 32'(bus.buf_ready), 32'd1);
        check("rel_free",  32'(bus.buf_free), 32'd1);
        rd(4'd2, 4'd3);
        check("b1_w3", bus.mac_rd_w3, 32'h1023);
        check("b1_w1", bus.mac_rd_w1, 32'hB003);

        // Release bank1 while bank0 reloads
        load_range(8'd9, 0, 80, 32'h4000, 32'hC000);
        pulse_release();
        check("mid_ready", 32'(bus.buf_ready), 32'd0);
        check("mid_free",  32'(bus.buf_free), 32'd1);
        rd(4'd5, 4'd5);
        check("nr_vld", 32'(bus.mac_rd_vld), 32'd0);
        check("nr_w3",  bus.mac_rd_w3, 32'h1023);
        check("nr_w1",  bus.mac_rd_w1, 32'hB003);
        load_range(8'd9, 80, 160, 32'h4000, 32'hC000);
        pulse_done();
        check("b0r_ready", 32'(bus.buf_ready), 32'd1);
        check("b0r_och",   32'(bus.mac_rd_och), 32'd9);
        rd(4'd0, 4'd1);
        check("b0r_w3", bus.mac_rd_w3, 32'h4001);
        check("b0r_w1", bus.mac_rd_w1, 32'hC001);

        // Both full, done and release on the same bank in one cycle
        load_range(8'd3, 0, 160, 32'h2000, 32'hD000);
        pulse_done();
        check("ff_free", 32'(bus.buf_free), 32'd0);
        bus.weight_done = 1'b1;
        bus.mac_release = 1'b1;
        @(negedge clk);
        bus.weight_done = 1'b0;
        bus.mac_release = 1'b0;
        check("dr_err",   32'(bus.wr_err), 32'd1);
        check("dr_free",  32'(bus.buf_free), 32'd1);
        check("dr_ready", 32'(bus.buf_ready), 32'd1);
        check("dr_och",   32'(bus.mac_rd_och), 32'd3);
        rd(4'd0, 4'd1);
        check("dr_w3", bus.mac_rd_w3, 32'h2001);
        check("dr_w1", bus.mac_rd_w1, 32'hD001);

        // Asynchronous reset in the middle of a load
        load_range(8'd11, 0, 70, 32'h5000, 32'hE000);
        #2 rst_n = 1'b0;
        #1;
        check("ar_free",  32'(bus.buf_free), 32'd1);
        check("ar_ready", 32'(bus.buf_ready), 32'd0);
        check("ar_och",   32'(bus.mac_rd_och), 32'd0);
        check("ar_err",   32'(bus.wr_err), 32'd0);
        check("ar_w3",    bus.mac_rd_w3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh load after reset
        load_range(8'd4, 0, 160, 32'h3000, 32'hF000);
        pulse_done();
        check("pr_och", 32'(bus.mac_rd_och), 32'd4);
        check("pr_err", 32'(bus.wr_err), 32'd0);
        rd(4'd8, 4'd15);
        check("pr_w3", bus.mac_rd_w3, 32'h3000 + 32'd143);
        check("pr_w1", bus.mac_rd_w1, 32'hF00F);

`ifdef WEIGHT_BUF_CHK_EN
        // Short load flagged on completion
        load_range(8'd6, 0, 159, 32'h6000, 32'h9000);
        pulse_done();
        check("short_err", 32'(bus.wr_err), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
